// File: rtl/ds_160_sched.sv
// Round-robin byte scheduler in front of the ds_160 8-bit serializer.
// It grants one requester per byte, loads the serializer and flags the cycles that carry valid bits.
module ds_160_sched #(
  parameter int NREQ = 4,
  parameter int SRCW = 2
) (
  input  logic                clock_160,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
  input  logic                hold,
  output logic [NREQ-1:0]     gnt,
  output logic                ser_load,
  output logic [7:0]          ser_data,
  output logic                bit_valid,
  output logic [SRCW-1:0]     cur_src,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam logic [SRCW:0]   NREQ_V   = (SRCW+1)'(NREQ);
  localparam logic [SRCW-1:0] LAST_IDX = SRCW'(NREQ-1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  state_t          state_r;
  logic [SRCW-1:0] ptr_r;
  logic [SRCW-1:0] src_r;
  logic [2:0]      cnt_r;

  logic [SRCW:0]   sum_s;
  logic [SRCW-1:0] cand_s;
  logic [SRCW-1:0] win_idx_s;
  logic [7:0]      win_data_s;
  logic            found_s;
  logic            win_s;
  logic            take_s;

  // Round-robin search starting at ptr_r, winner byte select and grant decision
  always_comb begin
    found_s    = 1'b0;
    win_idx_s  = '0;
    sum_s      = '0;
    cand_s     = '0;
    win_data_s = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      sum_s     = {1'b0, ptr_r} + (SRCW+1)'(k);
      cand_s    = (sum_s >= NREQ_V) ? SRCW'(sum_s - NREQ_V) : sum_s[SRCW-1:0];
      win_idx_s = (!found_s && req[cand_s]) ? cand_s : win_idx_s;
      found_s   = found_s | req[cand_s];
    end
    for (int j = 0; j < NREQ; j++) begin
      win_data_s = (SRCW'(j) == win_idx_s) ? req_data[8*j +: 8] : win_data_s;
    end
    win_s  = found_s & ~hold;
    // Grants happen from IDLE or on the last shift cycle (back-to-back)
    take_s = win_s & ((state_r == IDLE) | ((state_r == SHIFT) & (cnt_r == 3'd7)));
  end

  // Scheduler FSM with all outputs registered
  always_ff @(posedge clock_160 or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      ptr_r     <= '0;
      src_r     <= '0;
      cnt_r     <= 3'd0;
      gnt       <= '0;
      ser_load  <= 1'b0;
      ser_data  <= 8'h00;
      bit_valid <= 1'b0;
      cur_src   <= '0;
      busy      <= 1'b0;
    end else begin
      gnt      <= take_s ? (ONE_HOT0 << win_idx_s) : '0;
      ser_load <= take_s;
      if (take_s) begin
        ser_data <= win_data_s;
        src_r    <= win_idx_s;
        ptr_r    <= (win_idx_s == LAST_IDX) ? '0 : win_idx_s + SRCW'(1);
      end
      // The serializer output lags the shift state by one cycle
      bit_valid <= (state_r == SHIFT);
      if (state_r == SHIFT) begin
        cur_src <= src_r;
      end
      cnt_r <= (state_r == SHIFT) ? cnt_r + 3'd1 : 3'd0;
      case (state_r)
        IDLE: begin
          busy    <= take_s;
          state_r <= take_s ? LOAD : IDLE;
        end
        LOAD: begin
          busy    <= 1'b1;
          state_r <= SHIFT;
        end
        SHIFT: begin
          if (cnt_r == 3'd7) begin
            busy    <= take_s;
            state_r <= take_s ? LOAD : IDLE;
          end else begin
            busy    <= 1'b1;
            state_r <= SHIFT;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ds_160_sched.md
# ds_160_sched

Round-robin byte scheduler that shares the 160 MHz 8-bit serializer `ds_160` between `NREQ` requesters. It arbitrates pending byte requests and captures the winner's byte. It drives the serializer's load (`enable`) and `data_in`, then counts the 8 shift cycles. It also marks the cycles in which `ds_160.data_out` carries a valid bit. It sits directly in front of `ds_160` in the 160 MHz domain and shares its clock and reset.

## Interface

- `NREQ`, default 4: number of requesters, range 2..8.
- `SRCW`, default 2: width of `cur_src`; must equal clog2(`NREQ`).

- `clock_160`, input, 1: 160 MHz clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req`, input, `NREQ`: request per source; held high until granted.
- `req_data`, input, 8*`NREQ`: byte for source i, on bits [8i+7:8i]; stable while `req[i]` is high.
- `hold`, input, 1: blocks new grants while high; the byte in flight completes.
- `gnt`, output, `NREQ`: one-hot, one-cycle pulse; the source's byte has been captured.
- `ser_load`, output, 1: drives `ds_160.enable`.
- `ser_data`, output, 8: drives `ds_160.data_in`.
- `bit_valid`, output, 1: high while `ds_160.data_out` holds a valid bit of the current byte.
- `cur_src`, output, `SRCW`: index of the source whose bits are currently flagged by `bit_valid`.
- `busy`, output, 1: high from grant until the last shift edge.

## Operation

- All outputs are registered.
- Reset values: `gnt`=0, `ser_load`=0, `ser_data`=8'h00, `bit_valid`=0, `cur_src`=0, `busy`=0, state=IDLE, RR pointer=0, bit counter=0.
- States:
  - IDLE: a winner exists when any `req` is high and `hold`=0. On a winner, next cycle `gnt[w]`=1, `ser_load`=1, `ser_data`=`req_data[w]`, `busy`=1; go to LOAD.
  - LOAD: one cycle. Clear `gnt` and `ser_load`; counter=0; go to SHIFT.
  - SHIFT: 8 cycles, counter 0..7. On counter=7:
    - if a winner exists, perform the grant/load as in IDLE and go to LOAD (back-to-back);
    - otherwise `busy`=0 and go to IDLE.
- Arbitration is round-robin. Search starts at index `ptr`, ascending and wrapping at `NREQ`-1 to 0; the first high `req` wins. After a grant, `ptr`=(w+1) mod `NREQ`.
- The counter is 3 bits and must not run outside SHIFT.
- `bit_valid` generation:
  - `ser_load` high in cycle L means the serializer loads at the end of L.
  - Shift edges occur at the ends of cycles L+1..L+8.
  - Bit i is valid in cycle L+2+i, so `bit_valid` is high in cycles L+2..L+9.
  - `cur_src` updates to w in cycle L+2.
- A request that drops before it is granted is simply not granted. There is no error.
- `hold` rising during SHIFT has no effect on the current byte.
- Reset mid-operation aborts the byte with no partial completion; the next grant starts from source 0.

## Timing

- Request-to-grant latency: `req` high in IDLE at cycle T gives `gnt` and `ser_load` in T+1. First valid bit in T+3, last in T+10.
- Back-to-back byte period is 9 cycles, because the serializer loses one cycle per load. `bit_valid` is low exactly one cycle between consecutive bytes (cycle L+10 = L'+1).
- Sustained throughput: 8 bits per 9 clocks.
- The `req`-to-`gnt` path is combinational into a register only. Minimum grant spacing is 9 cycles.
- `reset` clears all state asynchronously; the first grant is possible one cycle after reset deassertion. `ds_160` resets synchronously, so `reset` must be held for at least one `clock_160` edge.

## Test plan

- Single request: `req`=0001, `req_data[7:0]`=8'hA5, after reset → `gnt`=0001 in T+1. `bit_valid` high for exactly 8 cycles; `data_out` sequence 1,0,1,0,0,1,0,1 (LSB first); `busy` falls after the 8th shift; returns to IDLE.
- All four requesting continuously with bytes 8'h01/02/04/08 → grant order 0,1,2,3,0 at 9-cycle spacing. `bit_valid` gap is exactly 1 cycle; each byte is reconstructed correctly with the matching `cur_src`.
- Fairness wrap: after granting source 3, `req`=1001 → source 0 granted next. `ptr`=2 with `req`=0011 → source 0 (wrap).
- `hold`: assert in the middle of a byte with `req`=0110 → current byte completes all 8 bits, then no `gnt` while `hold`=1. Deassert → source per `ptr` is granted in the next cycle.
- Reset mid-byte, at counter=4 → all outputs 0 immediately (asynchronously). After release, `req`=1100 grants source 2 (`ptr`=0 start).
- Request withdrawn: `req[1]` pulses low before arbitration while `req[2]` is high → only source 2 is granted; `gnt[1]` never asserts.
